vx_alu_req_arb: RTL and testbench

Shares one ALU request port (`VX_alu_unit` slave side) among `NUM_REQS` issue-side requesters. It does this with round-robin arbitration, an optional registered output stage and an in-flight limit. Grants are recorded in an in-order tag FIFO, so every ALU commit handshake is routed back to the requester that issued it as a one-cycle completion pulse. The block sits between the per-warp issue queues and the ALU unit.

---
 rtl/vx_alu_req_arb.sv | 134 +++++++++++++
 tb/tb_vx_alu_req_arb.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/vx_alu_req_arb.sv
// Round-robin arbiter sharing one ALU request port among NUM_REQS issuers, with an in-order
// tag FIFO for routing commits back. Define ALU_ARB_OUT_REG_EN for a registered output stage.
module vx_alu_req_arb #(
  parameter int NUM_REQS     = 4,
  parameter int DATAW        = 256,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQS-1:0]               req_valid_in,
  input  logic [NUM_REQS*DATAW-1:0]         req_data_in,
  output logic [NUM_REQS-1:0]               req_ready_in,
  output logic                              alu_valid_out,
  output logic [DATAW-1:0]                  alu_data_out,
  input  logic                              alu_ready_out,
  input  logic                              cmt_fire,
  output logic [NUM_REQS-1:0]               rsp_valid_out,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight_out,
  output logic                              err_underflow
);

  localparam int IDXW = $clog2(NUM_REQS);
  localparam int PTRW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int CNTW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CNTW-1:0] MAX_CNT = CNTW'(MAX_INFLIGHT);

  function automatic logic [IDXW-1:0] rr_offset(input logic [IDXW-1:0] base, input int k);
    int j;
    j = int'(base) + k;
    if (j >= NUM_REQS) j = j - NUM_REQS;
    return IDXW'(j);
  endfunction

  function automatic logic [IDXW-1:0] rr_next(input logic [IDXW-1:0] idx);
    if (int'(idx) == NUM_REQS - 1) return '0;
    return idx + 1'b1;
  endfunction

  logic [IDXW-1:0]     r_rr_ptr;
  logic [CNTW-1:0]     r_inflight;
  logic [PTRW-1:0]     r_wptr;
  logic [PTRW-1:0]     r_rptr;
  logic [IDXW-1:0]     r_tag_mem [MAX_INFLIGHT];
  logic [NUM_REQS-1:0] r_rsp_p1;
  logic                r_err;

  logic                w_accept;
  logic                w_room;
  logic                w_pop;
  logic                w_push;
  logic                w_underflow;
  logic [NUM_REQS-1:0] w_elig;
  logic [NUM_REQS-1:0] w_gnt_oh;
  logic                w_gnt_any;
  logic [IDXW-1:0]     w_gnt_idx;
  logic [DATAW-1:0]    w_gnt_data;

  // Stage p0: eligibility and round-robin pick. A same-cycle pop frees a slot when full.
  assign w_pop       = cmt_fire && (r_inflight != '0);
  assign w_underflow = cmt_fire && (r_inflight == '0);
  assign w_room      = (r_inflight < MAX_CNT) || w_pop;
  assign w_elig      = (reset || !w_room || !w_accept) ? '0 : req_valid_in;

  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      if (!w_gnt_any && w_elig[rr_offset(r_rr_ptr, k)]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = rr_offset(r_rr_ptr, k);
      end
    end
  end

  assign w_gnt_oh     = w_gnt_any ? (NUM_REQS'(1) << w_gnt_idx) : '0;
  assign w_gnt_data   = req_data_in[int'(w_gnt_idx)*DATAW +: DATAW];
  assign w_push       = w_gnt_any;
  assign req_ready_in = w_gnt_oh;

`ifdef ALU_ARB_OUT_REG_EN
  logic             r_vld_p1;
  logic [DATAW-1:0] r_data_p1;

  // Stage p1: one-entry output register, refillable in the cycle it drains.
  assign w_accept = alu_ready_out || !r_vld_p1;

  always_ff @(posedge clk) begin
    if (reset)              r_vld_p1 <= 1'b0;
    else if (w_push)        r_vld_p1 <= 1'b1;
    else if (alu_ready_out) r_vld_p1 <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_data_p1 <= w_gnt_data;
  end

  assign alu_valid_out = r_vld_p1;
  assign alu_data_out  = r_data_p1;
`else
  assign w_accept      = alu_ready_out;
  assign alu_valid_out = w_gnt_any;
  assign alu_data_out  = w_gnt_data;
`endif

  // Stage p1: tag FIFO, in-flight count and completion pulse.
  always_ff @(posedge clk) begin
    if (w_push) r_tag_mem[r_wptr] <= w_gnt_idx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr   <= '0;
      r_inflight <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_rsp_p1   <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_push) begin
        r_rr_ptr <= rr_next(w_gnt_idx);
        r_wptr   <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_inflight <= r_inflight + CNTW'(w_push) - CNTW'(w_pop);
      r_rsp_p1   <= w_pop ? (NUM_REQS'(1) << r_tag_mem[r_rptr]) : '0;
      if (w_underflow) r_err <= 1'b1;
    end
  end

  assign rsp_valid_out = r_rsp_p1;
  assign inflight_out  = r_inflight;
  assign err_underflow = r_err;

endmodule

// File: tb/tb_vx_alu_req_arb.sv
// Scoreboard bench for vx_alu_req_arb: grants push requester tags, commits pop them and the
// popped tag is compared against the completion pulse one cycle later.
module tb_vx_alu_req_arb;
  localparam int N  = 4;
  localparam int DW = 256;
  localparam int MI = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req_valid_in;
  logic [N*DW-1:0] req_data_in;
  logic [N-1:0]  req_ready_in;
  logic          alu_valid_out;
  logic [DW-1:0] alu_data_out;
  logic          alu_ready_out;
  logic          cmt_fire;
  logic [N-1:0]  rsp_valid_out;
  logic [2:0]    inflight_out;
  logic          err_underflow;

  always #5 clk = ~clk;

  vx_alu_req_arb #(.NUM_REQS(N), .DATAW(DW), .MAX_INFLIGHT(MI)) dut (
    .clk(clk), .reset(reset), .req_valid_in(req_valid_in), .req_data_in(req_data_in),
    .req_ready_in(req_ready_in), .alu_valid_out(alu_valid_out), .alu_data_out(alu_data_out),
    .alu_ready_out(alu_ready_out), .cmt_fire(cmt_fire), .rsp_valid_out(rsp_valid_out),
    .inflight_out(inflight_out), .err_underflow(err_underflow)
  );

  int checks = 0;
  int errors = 0;

  // reference state
  int          m_rr, m_infl, m_pidx;
  bit          m_err, m_pvld;
  int          q_tag[$];
  logic [N-1:0] m_rsp;
  logic [DW-1:0] m_data [N];

  // per-cycle expectations and observations
  logic [N-1:0]  exp_gnt, obs_gnt, obs_rsp;
  logic          exp_avld, obs_avld, obs_err;
  logic [DW-1:0] exp_adata, obs_adata;
  int            obs_infl;

  // Drive one cycle starting at a negedge; returns at the next negedge.
  task automatic cycle(input logic [N-1:0] v, input logic c, input logic r, input logic rst);
    bit accept, room;
    int w;
    reset = rst; req_valid_in = v; cmt_fire = c; alu_ready_out = r;
    #1;
`ifdef ALU_ARB_OUT_REG_EN
    accept = r || !m_pvld;
`else
    accept = r;
`endif
    room = (m_infl < MI) || (c && m_infl > 0);
    w = -1;
    if (!rst && accept && room)
      for (int k = 0; k < N; k++) begin
        int j = (m_rr + k) % N;
        if (w < 0 && v[j]) w = j;
      end
    exp_gnt = '0;
    if (w >= 0) exp_gnt[w] = 1'b1;
    obs_gnt = req_ready_in;
`ifndef ALU_ARB_OUT_REG_EN
    exp_avld  = (w >= 0);
    exp_adata = (w >= 0) ? m_data[w] : m_data[0];
    obs_avld  = alu_valid_out;
    obs_adata = alu_data_out;
`endif
    @(negedge clk);
    if (rst) begin
      q_tag.delete(); m_infl = 0; m_rr = 0; m_err = 0; m_rsp = '0; m_pvld = 0;
    end else begin
      m_rsp = '0;
      if (c && q_tag.size() > 0) begin
        int t = q_tag.pop_front();
        m_rsp[t] = 1'b1;
      end else if (c) m_err = 1;
      if (w >= 0) begin
        q_tag.push_back(w);
        m_rr = (w + 1) % N;
      end
      m_infl = q_tag.size();
      if (w >= 0) begin m_pvld = 1; m_pidx = w; end
      else if (r) m_pvld = 0;
    end
`ifdef ALU_ARB_OUT_REG_EN
    exp_avld  = m_pvld;
    exp_adata = m_data[m_pidx];
    obs_avld  = alu_valid_out;
    obs_adata = alu_data_out;
`endif
    obs_rsp  = rsp_valid_out;
    obs_infl = int'(inflight_out);
    obs_err  = err_underflow;
  endtask

  task automatic test_reset();
    cycle(4'hF, 1'b0, 1'b1, 1'b1);
    checks++; if (obs_gnt !== 4'b0) begin errors++; $display("FAIL reset_ready: got %b want 0000", obs_gnt); end
    checks++; if (obs_avld !== 1'b0) begin errors++; $display("FAIL reset_avld: got %b want 0", obs_avld); end
    checks++; if (obs_rsp !== 4'b0) begin errors++; $display("FAIL reset_rsp: got %b want 0000", obs_rsp); end
    checks++; if (obs_infl !== 0) begin errors++; $display("FAIL reset_infl: got %0d want 0", obs_infl); end
    checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", obs_err); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] want;
    cycle(4'h0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 12; i++) begin
      cycle(4'hF, i > 0, 1'b1, 1'b0);
      want = '0; want[i % N] = 1'b1;
      checks++; if (obs_gnt !== want) begin errors++; $display("FAIL rr_grant[%0d]: got %b want %b", i, obs_gnt, want); end
      checks++; if (obs_rsp !== m_rsp) begin errors++; $display("FAIL rr_rsp[%0d]: got %b want %b", i, obs_rsp, m_rsp); end
      checks++; if (obs_avld !== exp_avld || (exp_avld && obs_adata !== exp_adata)) begin
        errors++; $display("FAIL rr_alu[%0d]: got v=%b d=%h want v=%b d=%h", i, obs_avld, obs_adata[31:0], exp_avld, exp_adata[31:0]);
      end
    end
    cycle(4'h0, 1'b1, 1'b1, 1'b0);
    checks++; if (obs_rsp !== 4'b1000) begin errors++; $display("FAIL rr_last_rsp: got %b want 1000", obs_rsp); end
    checks++; if (obs_infl !== 0 || obs_err !== 1'b0) begin errors++; $display("FAIL rr_end: got infl=%0d err=%b want 0 0", obs_infl, obs_err); end
  endtask

  task automatic test_inflight_limit();
    logic [N-1:0] want;
    cycle(4'h0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle(4'hF, 1'b0, 1'b1, 1'b0);
      want = '0; want[i] = 1'b1;
      checks++; if (obs_gnt !== want) begin errors++; $display("FAIL lim_grant[%0d]: got %b want %b", i, obs_gnt, want); end
    end
    cycle(4'hF, 1'b0, 1'b1, 1'b0);
    checks++; if (obs_gnt !== 4'b0) begin errors++; $display("FAIL lim_no5th: got %b want 0000", obs_gnt); end
    checks++; if (obs_infl !== 4) begin errors++; $display("FAIL lim_infl: got %0d want 4", obs_infl); end
    cycle(4'h0, 1'b1, 1'b1, 1'b0);
    checks++; if (obs_rsp !== 4'b0001) begin errors++; $display("FAIL lim_rsp: got %b want 0001", obs_rsp); end
    checks++; if (obs_infl !== 3) begin errors++; $display("FAIL lim_infl3: got %0d want 3", obs_infl); end
    cycle(4'hF, 1'b0, 1'b1, 1'b0);
    checks++; if (obs_gnt !== 4'b0001) begin errors++; $display("FAIL lim_regrant: got %b want 0001", obs_gnt); end
    checks++; if (obs_infl !== 4) begin errors++; $display("FAIL lim_refill: got %0d want 4", obs_infl); end
  endtask

  task automatic test_full_simul();
    cycle(4'hF, 1'b1, 1'b1, 1'b0);
    checks++; if (obs_gnt !== 4'b0010) begin errors++; $display("FAIL full_grant: got %b want 0010", obs_gnt); end
    checks++; if (obs_rsp !== m_rsp) begin errors++; $display("FAIL full_rsp: got %b want %b", obs_rsp, m_rsp); end
    checks++; if (obs_infl !== 4) begin errors++; $display("FAIL full_infl: got %0d want 4", obs_infl); end
    for (int i = 0; i < 4; i++) begin
      cycle(4'h0, 1'b1, 1'b1, 1'b0);
      checks++; if (obs_rsp !== m_rsp) begin errors++; $display("FAIL full_drain[%0d]: got %b want %b", i, obs_rsp, m_rsp); end
    end
    checks++; if (obs_infl !== 0 || obs_err !== 1'b0) begin errors++; $display("FAIL full_end: got infl=%0d err=%b want 0 0", obs_infl, obs_err); end
  endtask

  task automatic test_backpressure();
    cycle(4'h0, 1'b0, 1'b1, 1'b1);
`ifdef ALU_ARB_OUT_REG_EN
    cycle(4'b0100, 1'b0, 1'b0, 1'b0);
    checks++; if (obs_gnt !== 4'b0100) begin errors++; $display("FAIL bp_grant: got %b want 0100", obs_gnt); end
    for (int i = 0; i < 3; i++) begin
      cycle(4'hF, 1'b0, 1'b0, 1'b0);
      checks++; if (obs_gnt !== 4'b0) begin errors++; $display("FAIL bp_hold_gnt[%0d]: got %b want 0000", i, obs_gnt); end
      checks++; if (obs_avld !== 1'b1 || obs_adata !== m_data[2]) begin
        errors++; $display("FAIL bp_hold_data[%0d]: got v=%b d=%h want v=1 d=%h", i, obs_avld, obs_adata[31:0], m_data[2][31:0]);
      end
    end
    cycle(4'hF, 1'b0, 1'b1, 1'b0);
    checks++; if (obs_gnt !== 4'b1000) begin errors++; $display("FAIL bp_resume: got %b want 1000", obs_gnt); end
    checks++; if (obs_adata !== m_data[3]) begin errors++; $display("FAIL bp_newdata: got %h want %h", obs_adata[31:0], m_data[3][31:0]); end
`else
    for (int i = 0; i < 3; i++) begin
      cycle(4'hF, 1'b0, 1'b0, 1'b0);
      checks++; if (obs_gnt !== 4'b0 || obs_avld !== 1'b0) begin
        errors++; $display("FAIL bp_stall[%0d]: got gnt=%b v=%b want 0000 0", i, obs_gnt, obs_avld);
      end
    end
    cycle(4'hF, 1'b0, 1'b1, 1'b0);
    checks++; if (obs_gnt !== 4'b0001) begin errors++; $display("FAIL bp_resume: got %b want 0001", obs_gnt); end
    checks++; if (obs_avld !== 1'b1 || obs_adata !== m_data[0]) begin
      errors++; $display("FAIL bp_data: got v=%b d=%h want v=1 d=%h", obs_avld, obs_adata[31:0], m_data[0][31:0]);
    end
`endif
    for (int i = 0; i < 8 && m_infl > 0; i++) begin
      cycle(4'h0, 1'b1, 1'b1, 1'b0);
      checks++; if (obs_rsp !== m_rsp) begin errors++; $display("FAIL bp_drain[%0d]: got %b want %b", i, obs_rsp, m_rsp); end
    end
  endtask

  task automatic test_underflow();
    cycle(4'h0, 1'b0, 1'b1, 1'b1);
    cycle(4'h0, 1'b1, 1'b1, 1'b0);
    checks++; if (obs_err !== 1'b1) begin errors++; $display("FAIL uf_err: got %b want 1", obs_err); end
    checks++; if (obs_rsp !== 4'b0 || obs_infl !== 0) begin errors++; $display("FAIL uf_state: got rsp=%b infl=%0d want 0000 0", obs_rsp, obs_infl); end
    cycle(4'h0, 1'b0, 1'b1, 1'b0);
    checks++; if (obs_err !== 1'b1) begin errors++; $display("FAIL uf_sticky: got %b want 1", obs_err); end
  endtask

  task automatic test_reset_midflight();
    cycle(4'h0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cycle(4'hF, 1'b0, 1'b1, 1'b0);
    checks++; if (obs_infl !== 3) begin errors++; $display("FAIL mid_infl3: got %0d want 3", obs_infl); end
    cycle(4'h0, 1'b0, 1'b1, 1'b1);
    checks++; if (obs_infl !== 0 || obs_rsp !== 4'b0 || obs_err !== 1'b0 || obs_avld !== 1'b0) begin
      errors++; $display("FAIL mid_reset: got infl=%0d rsp=%b err=%b v=%b want all 0", obs_infl, obs_rsp, obs_err, obs_avld);
    end
    cycle(4'b0100, 1'b0, 1'b1, 1'b0);
    checks++; if (obs_gnt !== 4'b0100) begin errors++; $display("FAIL mid_req2: got %b want 0100", obs_gnt); end
    cycle(4'h0, 1'b1, 1'b1, 1'b0);
    checks++; if (obs_rsp !== 4'b0100) begin errors++; $display("FAIL mid_rsp2: got %b want 0100", obs_rsp); end
    for (int i = 0; i < 3; i++) cycle(4'hF, 1'b0, 1'b1, 1'b0);
    cycle(4'h0, 1'b0, 1'b1, 1'b1);
    cycle(4'b1010, 1'b1, 1'b1, 1'b0);
    checks++; if (obs_gnt !== 4'b0010) begin errors++; $display("FAIL mid_rrptr: got %b want 0010", obs_gnt); end
    checks++; if (obs_err !== 1'b1 || obs_rsp !== 4'b0) begin errors++; $display("FAIL mid_uf: got err=%b rsp=%b want 1 0000", obs_err, obs_rsp); end
  endtask

  initial begin
    reset = 1'b1; req_valid_in = '0; cmt_fire = 1'b0; alu_ready_out = 1'b1;
    m_rr = 0; m_infl = 0; m_pidx = 0; m_err = 0; m_pvld = 0; m_rsp = '0;
    for (int i = 0; i < N; i++) begin
      m_data[i] = {8{32'hC0DE_0000 + 32'(i)}};
      req_data_in[i*DW +: DW] = m_data[i];
    end
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_inflight_limit();
    test_full_simul();
    test_backpressure();
    test_underflow();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
